// File: rtl/moving_avg_pkg.sv
// Shared types and width helper for the variable-window moving-sum filter.
package moving_avg_pkg;

  function automatic int acc_bits(input int data_bits, input int delay_bits);
    return data_bits + delay_bits;
  endfunction

  localparam int DATA_BITS_DEF  = 12;
  localparam int DELAY_BITS_DEF = 4;
  localparam int ACC_BITS_DEF   = acc_bits(DATA_BITS_DEF, DELAY_BITS_DEF);

  typedef logic signed [DATA_BITS_DEF-1:0] sample_t;
  typedef logic signed [ACC_BITS_DEF-1:0]  acc_t;

endpackage

// File: rtl/variable_delay_accumulator.sv
// One channel: sample shift register, DELAY-indexed tap, running-sum accumulator
// and the signed top-bit slice of that sum.
module variable_delay_accumulator
  import moving_avg_pkg::*;
#(
  parameter int DATA_BITS     = 12,
  parameter int DELAY_BITS    = 4,
  parameter int TOP_DATA_BITS = 4,
  localparam int ACC_BITS     = acc_bits(DATA_BITS, DELAY_BITS)
) (
  input  logic                        clk,
  input  logic                        ce,
  input  logic                        flush,
  input  logic signed [DATA_BITS-1:0] sample,
  input  logic [DELAY_BITS-1:0]       delay,
  output logic signed [ACC_BITS-1:0]  acc,
  output logic [TOP_DATA_BITS-1:0]    top
);

  localparam int DEPTH = 1 << DELAY_BITS;

  logic signed [DATA_BITS-1:0] sr_p0 [DEPTH];
  logic signed [ACC_BITS-1:0]  acc_p1;
  logic signed [ACC_BITS-1:0]  sample_ext;
  logic signed [ACC_BITS-1:0]  tap_ext;

  // The tap leaving the window is read before the shift, so the window is DELAY+1 long.
  assign sample_ext = {{DELAY_BITS{sample[DATA_BITS-1]}}, sample};
  assign tap_ext    = {{DELAY_BITS{sr_p0[delay][DATA_BITS-1]}}, sr_p0[delay]};

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) sr_p0[k] <= '0;
      acc_p1 <= '0;
    end else if (ce) begin
      sr_p0[0] <= sample;
      for (int k = 1; k < DEPTH; k++) sr_p0[k] <= sr_p0[k-1];
      acc_p1 <= acc_p1 + sample_ext - tap_ext;
    end
  end

  // --- output stage ---
  assign acc = acc_p1;
  assign top = acc_p1[ACC_BITS-1 -: TOP_DATA_BITS];

endmodule

// File: rtl/moving_avg_variable_delay.sv
// Variable-window moving-sum filter for the SIN/COS channels, with the fill/VALID
// tracking and the periodic UPDATE strobe for the autoscale controller.
module moving_avg_variable_delay
  import moving_avg_pkg::*;
#(
  parameter int DATA_BITS          = 12,
  parameter int DELAY_BITS         = 4,
  parameter int TOP_DATA_BITS      = 4,
  parameter int UPDATE_PERIOD_BITS = 3,
  localparam int ACC_BITS          = acc_bits(DATA_BITS, DELAY_BITS)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CE,
  input  logic signed [DATA_BITS-1:0] IN_SIN,
  input  logic signed [DATA_BITS-1:0] IN_COS,
  input  logic [DELAY_BITS-1:0]       DELAY,
  input  logic                        DELAY_UPDATED,
  output logic signed [ACC_BITS-1:0]  OUT_SIN,
  output logic signed [ACC_BITS-1:0]  OUT_COS,
  output logic [TOP_DATA_BITS-1:0]    TOP_SIN,
  output logic [TOP_DATA_BITS-1:0]    TOP_COS,
  output logic                        VALID,
  output logic                        UPDATE
);

  function automatic logic [DELAY_BITS:0] sat_inc(input logic [DELAY_BITS:0] cnt,
                                                  input logic [DELAY_BITS:0] limit);
    return (cnt == limit) ? cnt : cnt + 1'b1;
  endfunction

  logic                          flush;
  logic [DELAY_BITS:0]           window_len;
  logic [DELAY_BITS:0]           fill_cnt_p1;
  logic [DELAY_BITS:0]           fill_next;
  logic [UPDATE_PERIOD_BITS-1:0] period_cnt_p1;
  logic                          vld_p1;
  logic                          update_p1;

  // RESET and an enabled DELAY_UPDATED both restart the window from empty.
  assign flush      = RESET | (CE & DELAY_UPDATED);
  assign window_len = {1'b0, DELAY} + {{DELAY_BITS{1'b0}}, 1'b1};
  assign fill_next  = sat_inc(fill_cnt_p1, window_len);

  always_ff @(posedge CLK) begin
    if (flush) begin
      fill_cnt_p1   <= '0;
      period_cnt_p1 <= '0;
      vld_p1        <= 1'b0;
      update_p1     <= 1'b0;
    end else if (CE) begin
      fill_cnt_p1   <= fill_next;
      period_cnt_p1 <= period_cnt_p1 + 1'b1;
      vld_p1        <= (fill_next == window_len);
      update_p1     <= vld_p1 & (&period_cnt_p1);
    end else begin
      update_p1     <= 1'b0;
    end
  end

  variable_delay_accumulator #(
    .DATA_BITS    (DATA_BITS),
    .DELAY_BITS   (DELAY_BITS),
    .TOP_DATA_BITS(TOP_DATA_BITS)
  ) u_sin (
    .clk   (CLK),
    .ce    (CE),
    .flush (flush),
    .sample(IN_SIN),
    .delay (DELAY),
    .acc   (OUT_SIN),
    .top   (TOP_SIN)
  );

  variable_delay_accumulator #(
    .DATA_BITS    (DATA_BITS),
    .DELAY_BITS   (DELAY_BITS),
    .TOP_DATA_BITS(TOP_DATA_BITS)
  ) u_cos (
    .clk   (CLK),
    .ce    (CE),
    .flush (flush),
    .sample(IN_COS),
    .delay (DELAY),
    .acc   (OUT_COS),
    .top   (TOP_COS)
  );

  // --- output stage ---
  assign VALID  = vld_p1;
  assign UPDATE = update_p1;

endmodule

// File: tb/tb_moving_avg_variable_delay.sv
// Bench for moving_avg_variable_delay: directed vector table, corner sequences and
// randomized traffic against a sample-history reference model.
module tb_moving_avg_variable_delay;

  logic               CLK = 1'b0;
  logic               RESET, CE, DELAY_UPDATED;
  logic signed [11:0] IN_SIN, IN_COS;
  logic [3:0]         DELAY;
  logic signed [15:0] OUT_SIN, OUT_COS;
  logic [3:0]         TOP_SIN, TOP_COS;
  logic               VALID, UPDATE;

  moving_avg_variable_delay #(
    .DATA_BITS(12), .DELAY_BITS(4), .TOP_DATA_BITS(4), .UPDATE_PERIOD_BITS(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .IN_SIN(IN_SIN), .IN_COS(IN_COS),
    .DELAY(DELAY), .DELAY_UPDATED(DELAY_UPDATED), .OUT_SIN(OUT_SIN), .OUT_COS(OUT_COS),
    .TOP_SIN(TOP_SIN), .TOP_COS(TOP_COS), .VALID(VALID), .UPDATE(UPDATE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_delay = 0;
  int q_sin[$];
  int q_cos[$];
  int n_acc = 0;
  int m_update = 0;

  typedef struct {
    int delay; int sin; int cos; int ncyc;
    int e_sin; int e_cos; int e_tsin; int e_tcos; int e_valid;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wsum(input int q[$], input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += q[q.size()-1-i];
    return s;
  endfunction

  function automatic int top_of(input int v);
    logic [15:0] t;
    logic signed [3:0] tp;
    t  = v[15:0];
    tp = t[15:12];
    return int'(tp);
  endfunction

  task automatic check_all();
    int n, es, ec;
    n  = (q_sin.size() < cur_delay + 1) ? q_sin.size() : cur_delay + 1;
    es = wsum(q_sin, n);
    ec = wsum(q_cos, n);
    chk("out_sin", int'(OUT_SIN), es);
    chk("out_cos", int'(OUT_COS), ec);
    chk("top_sin", int'($signed(TOP_SIN)), top_of(es));
    chk("top_cos", int'($signed(TOP_COS)), top_of(ec));
    chk("valid", int'(VALID), (n_acc >= cur_delay + 1) ? 1 : 0);
    chk("update", int'(UPDATE), m_update);
  endtask

  task automatic cycle(input bit rst, input bit ce, input bit du, input int s, input int c);
    RESET = rst; CE = ce; DELAY_UPDATED = du;
    IN_SIN = s[11:0]; IN_COS = c[11:0]; DELAY = cur_delay[3:0];
    @(posedge CLK);
    if (rst || (ce && du)) begin
      q_sin.delete(); q_cos.delete();
      n_acc = 0; m_update = 0;
    end else if (ce) begin
      m_update = ((n_acc % 8) == 7 && n_acc >= cur_delay + 1) ? 1 : 0;
      q_sin.push_back(int'($signed(s[11:0])));
      q_cos.push_back(int'($signed(c[11:0])));
      if (q_sin.size() > 16) begin void'(q_sin.pop_front()); void'(q_cos.pop_front()); end
      n_acc++;
    end else begin
      m_update = 0;
    end
    #1;
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int upd_cnt, early, frozen;
    bit seen_valid;

    vecs[0] = '{3,  2047, -2048, 4,  8188,  -8192,  1, -2, 1};
    vecs[1] = '{15, 2047, -2048, 16, 32752, -32768, 7, -8, 1};
    vecs[2] = '{7,  2047, -2048, 8,  16376, -16384, 3, -4, 1};
    vecs[3] = '{7,  2047, -2048, 7,  14329, -14336, 3, -4, 0};
    vecs[4] = '{0,  100,  -5,    1,  100,   -5,     0, -1, 1};

    // Reset with random inputs, then free run: no UPDATE before VALID
    cur_delay = 5;
    repeat (5) cycle(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
    early = 0; seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 0, $urandom, $urandom);
      if (UPDATE && !seen_valid) early++;
      if (VALID) seen_valid = 1;
    end
    chk("update_before_valid", early, 0);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      cur_delay = vecs[v].delay;
      cycle(0, 1, 1, vecs[v].sin, vecs[v].cos);
      for (int i = 0; i < vecs[v].ncyc; i++) cycle(0, 1, 0, vecs[v].sin, vecs[v].cos);
      chk($sformatf("vec%0d_out_sin", v), int'(OUT_SIN), vecs[v].e_sin);
      chk($sformatf("vec%0d_out_cos", v), int'(OUT_COS), vecs[v].e_cos);
      chk($sformatf("vec%0d_top_sin", v), int'($signed(TOP_SIN)), vecs[v].e_tsin);
      chk($sformatf("vec%0d_top_cos", v), int'($signed(TOP_COS)), vecs[v].e_tcos);
      chk($sformatf("vec%0d_valid", v), int'(VALID), vecs[v].e_valid);
    end

    // DELAY=15: UPDATE every 8 CE cycles once full
    cur_delay = 15;
    cycle(0, 1, 1, 2047, -2048);
    repeat (16) cycle(0, 1, 0, 2047, -2048);
    upd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, 0, 2047, -2048);
      if (UPDATE) upd_cnt++;
    end
    chk("period_update_count", upd_cnt, 4);

    // Mid-stream DELAY change to 7: flush, silence for 8 samples, then new sum
    cur_delay = 7;
    cycle(0, 1, 1, 2047, -2048);
    chk("du_flush_out", int'(OUT_SIN), 0);
    chk("du_flush_valid", int'(VALID), 0);
    upd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 2047, -2048);
      if (UPDATE) upd_cnt++;
    end
    chk("du_no_update", upd_cnt, 0);
    chk("du_out_sin", int'(OUT_SIN), 16376);
    chk("du_top_sin", int'($signed(TOP_SIN)), 3);

    // CE low for 3 cycles freezes state; DELAY_UPDATED with CE=0 is ignored
    cycle(0, 1, 0, 5, -7);
    frozen = int'(OUT_SIN);
    cycle(0, 0, 0, 900, 900);
    cycle(0, 0, 1, 900, 900);
    cycle(0, 0, 0, 900, 900);
    chk("ce_low_hold", int'(OUT_SIN), frozen);
    chk("ce_low_valid", int'(VALID), 1);
    chk("ce_low_update", int'(UPDATE), 0);
    cycle(0, 1, 0, 11, 13);
    chk("ce_resume", int'(OUT_SIN), frozen + 11 - 2047);

    // UPDATE fires at the 8th accepted sample edge when full, flush suppresses it
    cur_delay = 3;
    cycle(0, 1, 1, 0, 0);
    repeat (7) cycle(0, 1, 0, 1, 1);
    cycle(0, 1, 0, 1, 1);
    chk("update_fires", int'(UPDATE), 1);
    cycle(0, 1, 1, 0, 0);
    repeat (7) cycle(0, 1, 0, 1, 1);
    cycle(0, 1, 1, 1, 1);
    chk("flush_beats_update", int'(UPDATE), 0);
    chk("flush_beats_update_out", int'(OUT_SIN), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, c, d;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 9) < 8);
      d = ($urandom_range(0, 29) == 0);
      if (c && d) cur_delay = $urandom_range(0, 15);
      cycle(r, c, d, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/moving_avg_variable_delay.md
# moving_avg_variable_delay

Variable-window moving-sum filter for the SIN and COS demodulator channels. It sits between the demodulator and `filter_autoscale_control`. It produces the filtered sums, their signed top bits and the UPDATE strobe that the controller consumes. It also accepts the DELAY / DELAY_UPDATED pair that the controller returns, which sets the window length to DELAY+1 samples.

## Interface
- DATA_BITS, 12, signed width of each input sample
- DELAY_BITS, 4, width of DELAY; maximum window is 2^DELAY_BITS samples
- TOP_DATA_BITS, 4, width of TOP_SIN / TOP_COS
- UPDATE_PERIOD_BITS, 3, UPDATE fires once every 2^UPDATE_PERIOD_BITS CE cycles; must be ≥3 so the controller's 4-stage pipeline drains between requests

Ports:
- CLK  in  1  single clock, rising edge
- RESET  in  1  synchronous, active-high
- CE  in  1  clock enable; all state advances only when CE=1
- IN_SIN  in  DATA_BITS  signed sample
- IN_COS  in  DATA_BITS  signed sample
- DELAY  in  DELAY_BITS  window = DELAY+1 samples; stable except in a DELAY_UPDATED cycle
- DELAY_UPDATED  in  1  one CE cycle pulse; DELAY already holds the new value in that cycle
- OUT_SIN  out  ACC_BITS  signed moving sum, ACC_BITS = DATA_BITS+DELAY_BITS
- OUT_COS  out  ACC_BITS  signed moving sum
- TOP_SIN  out  TOP_DATA_BITS  OUT_SIN[ACC_BITS-1 -: TOP_DATA_BITS]
- TOP_COS  out  TOP_DATA_BITS  OUT_COS[ACC_BITS-1 -: TOP_DATA_BITS]
- VALID  out  1  window is completely filled since the last flush
- UPDATE  out  1  one-cycle request to the controller; asserted only while VALID

## Operation
- Each channel keeps a shift register sr[0..2^DELAY_BITS-1] of past samples and an accumulator acc.
- On every CE cycle, with no flush:
  - sr[0] <= IN
  - sr[k] <= sr[k-1]
  - acc <= acc + IN − sr[DELAY]
- Full-width signed arithmetic; acc never overflows, because at most 2^DELAY_BITS samples are summed.
- The window is not normalised. Amplitude scales with DELAY+1, which is the quantity the autoscale loop regulates.
- Flush occurs when RESET=1, or when CE=1 and DELAY_UPDATED=1. On flush:
  - every sr entry, acc, fill_cnt and period_cnt are cleared
  - the input sample of that cycle is discarded
- Because sr is zeroed, acc is always the exact sum of the samples accepted since the flush, even before the window fills.
- fill_cnt has DELAY_BITS+1 bits. It increments per accepted sample and saturates at DELAY+1. VALID = (fill_cnt == DELAY+1).
- period_cnt has UPDATE_PERIOD_BITS bits and runs free modulo 2^P from the flush.
- UPDATE <= CE && VALID && (period_cnt == all ones) && !flush.
- Precedence: RESET over DELAY_UPDATED over normal accumulation.
- A DELAY_UPDATED pulse with CE=0 is ignored.

## Timing
- Reset values: OUT_SIN = OUT_COS = 0, TOP_SIN = TOP_COS = 0, VALID = 0, UPDATE = 0.
- All outputs are registered.
- OUT_* reflects the samples accepted up to and including the previous CE edge (latency 1 CE cycle). TOP_* and VALID are registered in the same cycle as OUT_*.
- After a flush, VALID rises on the edge that accepts sample number DELAY+1.
- After a flush, the first UPDATE occurs at the first period_cnt wrap on which VALID is set. Subsequent UPDATEs follow exactly every 2^P CE cycles.
- UPDATE is exactly one CLK wide. With CE=0 every output holds its value, except UPDATE, which is 0.
- When DELAY_UPDATED is asserted in the same cycle that UPDATE would fire, the flush wins and UPDATE stays 0.

## Structure
- Package `moving_avg_pkg`:
  - function `acc_bits(DATA_BITS, DELAY_BITS)`
  - typedef for the signed sample and accumulator types
- Sub-module `variable_delay_accumulator`, one instance per channel, containing:
  - the shift register
  - the DELAY-indexed tap mux
  - the accumulator
  - the top-bit slice
- Top level holds: fill_cnt, period_cnt, the UPDATE/VALID logic, and the flush decode shared by both channels.

## Test plan
Parameters: DATA_BITS=12, DELAY_BITS=4, TOP_DATA_BITS=4, P=3.

1. Hold RESET for 5 cycles with random inputs → all outputs 0. After release, no UPDATE before VALID.
2. DELAY=3, IN_SIN=2047, IN_COS=−2048 constant → after 4 CE cycles: OUT_SIN=8188, OUT_COS=−8192, TOP_SIN=1, TOP_COS=−2, VALID=1.
3. DELAY=15, same inputs → after 16 CE cycles: OUT_SIN=32752, TOP_SIN=7, OUT_COS=−32768, TOP_COS=−8. UPDATE pulses every 8 CE cycles, one cycle wide.
4. Mid-stream DELAY_UPDATED pulse with new DELAY=7 → next cycle OUT_*=0 and VALID=0. No UPDATE for 8 samples. Then OUT_SIN=16376, TOP_SIN=3.
5. Toggle CE low for 3 cycles during accumulation → OUT_*, VALID and the counters freeze; UPDATE=0. The sums resume exactly when CE returns.
6. Closed loop with `filter_autoscale_control`: sinusoidal inputs of amplitude 300 → DELAY settles, and TOP magnitudes stay inside the controller's target band with no UPDATE issued while its pipeline is busy.
